// File: rtl/dds_pkg.sv
// Shared types and helpers for the AD9850-class DDS power-up loader.
// Holds the controller state enum, the serial word widths and the word builder.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DDS_RST,
    SER_WCLK,
    SER_FQUD,
    SHIFT,
    LATCH,
    DONE
  } dds_state_e;

  localparam int DDS_WORD_W = 40;
  localparam int FTW_W      = 32;
  localparam int CTRL_W     = 8;
  localparam int IDX_W      = 6;
  localparam int RELOAD_W   = 20;

  // Serial word as the chip expects it, LSB first: tuning word then control byte.
  function automatic logic [DDS_WORD_W-1:0] build_word(input logic [FTW_W-1:0]  ftw,
                                                       input logic [CTRL_W-1:0] ctrl);
    return {ctrl, ftw};
  endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// Pin-phase timebase for the DDS loader.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   clr   - synchronous clear, restarts a full CLK_DIV-cycle period
//   tick  - high for one clk at the end of every CLK_DIV-cycle period
module dds_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Down-counter; terminal count at zero, then reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || (cnt == '0)) begin
      cnt <= CNT_W'(CLK_DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/dds_main.sv
// Power-up configuration controller for an AD9850-class DDS in 3-wire serial mode.
// After reset: pulse chip RESET, enter serial mode (W_CLK then FQ_UD pulse),
// shift {CTRL_BYTE, FREQ_WORD} LSB first on 40 W_CLK pulses, latch with FQ_UD.
// Ports:
//   clk   - system clock (100 MHz)       reset - async active-high reset
//   W_CLK - DDS word clock               FQ_UD - DDS frequency update strobe
//   DATA  - DDS serial data (D7)         RESET - DDS master reset
//   led1  - load complete (sticky)       led2  - sequence in progress
// Build option: define DDS_RELOAD_EN to re-send and re-latch the word every 2^20 clks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | reset just released, word register loaded
// DDS_RST  | RESET high for RST_CYCLES clks, then low for one tick
// SER_WCLK | first W_CLK pulse of the serial-mode entry
// SER_FQUD | FQ_UD pulse completing serial-mode entry
// SHIFT    | per bit: setup tick (W_CLK=0), hold tick (W_CLK=1)
// LATCH    | FQ_UD pulse loading the shifted word
// DONE     | load complete; terminal unless reload is enabled
module dds_main import dds_pkg::*; #(
  parameter logic [FTW_W-1:0]  FREQ_WORD  = 32'h147AE148,
  parameter logic [CTRL_W-1:0] CTRL_BYTE  = 8'h00,
  parameter int                CLK_DIV    = 2,
  parameter int                RST_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  output logic W_CLK,
  output logic FQ_UD,
  output logic DATA,
  output logic RESET,
  output logic led1,
  output logic led2
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DDS_WORD_W - 1);

  dds_state_e            state;
  logic                  phase;
  logic [RC_W-1:0]       rst_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      nxt_idx;
  logic [DDS_WORD_W-1:0] word_q;
  logic                  tick;
  logic                  tick_clr;
`ifdef DDS_RELOAD_EN
  logic [RELOAD_W-1:0]   reload_cnt;
`endif

  // Hold the timebase in reload wherever the FSM is not pacing on ticks, so the
  // first tick-timed phase after each of those states lasts exactly CLK_DIV clks.
  assign tick_clr = (state == IDLE) || (state == DONE) || ((state == DDS_RST) && !phase);
  assign nxt_idx  = bit_idx + IDX_W'(1);

  dds_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 1'b0;
      rst_cnt <= '0;
      bit_idx <= '0;
      word_q  <= '0;
      W_CLK   <= 1'b0;
      FQ_UD   <= 1'b0;
      DATA    <= 1'b0;
      RESET   <= 1'b0;
      led1    <= 1'b0;
      led2    <= 1'b0;
`ifdef DDS_RELOAD_EN
      reload_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state   <= DDS_RST;
          phase   <= 1'b0;
          rst_cnt <= RC_W'(RST_CYCLES - 1);
          word_q  <= build_word(FREQ_WORD, CTRL_BYTE);
          RESET   <= 1'b1;
          led2    <= 1'b1;
        end
        DDS_RST: begin
          if (!phase) begin
            if (rst_cnt == '0) begin
              RESET <= 1'b0;
              phase <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end else if (tick) begin
            state <= SER_WCLK;
            phase <= 1'b0;
            W_CLK <= 1'b1;
          end
        end
        SER_WCLK: begin
          if (tick) begin
            if (!phase) begin
              W_CLK <= 1'b0;
              phase <= 1'b1;
            end else begin
              state <= SER_FQUD;
              phase <= 1'b0;
              FQ_UD <= 1'b1;
            end
          end
        end
        SER_FQUD: begin
          if (tick) begin
            if (!phase) begin
              FQ_UD <= 1'b0;
              phase <= 1'b1;
            end else begin
              state   <= SHIFT;
              phase   <= 1'b0;
              bit_idx <= '0;
              DATA    <= word_q[0];
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!phase) begin
              W_CLK <= 1'b1;
              phase <= 1'b1;
            end else begin
              W_CLK <= 1'b0;
              phase <= 1'b0;
              if (bit_idx == LAST_IDX) begin
                // DATA keeps bit 39 until DONE so it never moves on a W_CLK edge.
                state <= LATCH;
                FQ_UD <= 1'b1;
              end else begin
                bit_idx <= nxt_idx;
                DATA    <= word_q[nxt_idx];
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            state <= DONE;
            FQ_UD <= 1'b0;
            DATA  <= 1'b0;
            led2  <= 1'b0;
            led1  <= 1'b1;
`ifdef DDS_RELOAD_EN
            reload_cnt <= '1;
`endif
          end
        end
        DONE: begin
`ifdef DDS_RELOAD_EN
          if (reload_cnt == '0) begin
            state   <= SHIFT;
            phase   <= 1'b0;
            bit_idx <= '0;
            DATA    <= word_q[0];
            led2    <= 1'b1;
          end else begin
            reload_cnt <= reload_cnt - 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_main.sv
// Self-checking bench for dds_main: default build plus a parameter-sweep instance.
module tb_dds_main;

  localparam logic [31:0] FTW_A  = 32'h147AE148;
  localparam logic [7:0]  CTRL_A = 8'h00;
  localparam int          DIV_A  = 2;
  localparam logic [31:0] FTW_B  = 32'hFFFFFFFF;
  localparam logic [7:0]  CTRL_B = 8'h04;
  localparam int          DIV_B  = 1;
  localparam int          RSTC   = 8;

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  logic w_a, f_a, d_a, r_a, l1_a, l2_a;
  logic w_b, f_b, d_b, r_b, l1_b, l2_b;
  logic [5:0] outs_a, outs_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dds_main dut_a (
    .clk(clk), .reset(reset_a), .W_CLK(w_a), .FQ_UD(f_a), .DATA(d_a),
    .RESET(r_a), .led1(l1_a), .led2(l2_a)
  );

  dds_main #(.FREQ_WORD(FTW_B), .CTRL_BYTE(CTRL_B), .CLK_DIV(DIV_B), .RST_CYCLES(RSTC)) dut_b (
    .clk(clk), .reset(reset_b), .W_CLK(w_b), .FQ_UD(f_b), .DATA(d_b),
    .RESET(r_b), .led1(l1_b), .led2(l2_b)
  );

  assign outs_a = {w_a, f_a, d_a, r_a, l1_a, l2_a};
  assign outs_b = {w_b, f_b, d_b, r_b, l1_b, l2_b};

  // Observed pin activity per DUT, rebuilt from waveforms sampled on negedge.
  int cyc[2], w_n[2], f_n[2], r_n[2];
  int w_run[2], f_run[2], r_run[2], w_min[2], w_max[2], f_min[2], f_max[2], r_len[2];
  int rfall_cyc[2], w1_cyc[2], w2_cyc[2], wlast_cyc[2], f1_cyc[2], f2_cyc[2], done_cyc[2];
  int overlap[2], glitch[2], both[2], rst_pins[2];
  logic led2_rst[2];
  logic pw[2], pf[2], pd[2], pr[2];
  logic [63:0] cap[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats(input int d);
    cyc[d] = 0; w_n[d] = 0; f_n[d] = 0; r_n[d] = 0;
    w_run[d] = 0; f_run[d] = 0; r_run[d] = 0;
    w_min[d] = 999; w_max[d] = 0; f_min[d] = 999; f_max[d] = 0; r_len[d] = 0;
    rfall_cyc[d] = 0; w1_cyc[d] = 0; w2_cyc[d] = 0; wlast_cyc[d] = 0;
    f1_cyc[d] = 0; f2_cyc[d] = 0; done_cyc[d] = 0;
    overlap[d] = 0; glitch[d] = 0; both[d] = 0; rst_pins[d] = 0;
    led2_rst[d] = 1'b0;
    pw[d] = 1'b0; pf[d] = 1'b0; pd[d] = 1'b0; pr[d] = 1'b0;
    cap[d] = '0;
  endtask

  task automatic sample(input int d, input logic [5:0] o);
    logic w, f, dt, r, l1, l2;
    {w, f, dt, r, l1, l2} = o;
    cyc[d]++;
    if (w && !pw[d]) begin
      w_n[d]++;
      if (w_n[d] == 1) w1_cyc[d] = cyc[d];
      if (w_n[d] == 2) w2_cyc[d] = cyc[d];
      wlast_cyc[d] = cyc[d];
      // First W_CLK pulse is serial-mode entry; the next 40 carry the word.
      if (w_n[d] >= 2 && w_n[d] <= 41) cap[d][w_n[d]-2] = dt;
    end
    if (w) w_run[d]++;
    else if (pw[d]) begin
      if (w_run[d] < w_min[d]) w_min[d] = w_run[d];
      if (w_run[d] > w_max[d]) w_max[d] = w_run[d];
      w_run[d] = 0;
    end
    if (f && !pf[d]) begin
      f_n[d]++;
      if (f_n[d] == 1) f1_cyc[d] = cyc[d];
      if (f_n[d] == 2) f2_cyc[d] = cyc[d];
    end
    if (f) f_run[d]++;
    else if (pf[d]) begin
      if (f_run[d] < f_min[d]) f_min[d] = f_run[d];
      if (f_run[d] > f_max[d]) f_max[d] = f_run[d];
      f_run[d] = 0;
    end
    if (r && !pr[d]) begin
      r_n[d]++;
      led2_rst[d] = l2;
    end
    if (r) r_run[d]++;
    else if (pr[d]) begin
      r_len[d] = r_run[d];
      r_run[d] = 0;
      rfall_cyc[d] = cyc[d];
    end
    if (w && f) overlap[d]++;
    if (pw[d] && w && (dt !== pd[d])) glitch[d]++;
    if (l1 && l2) both[d]++;
    if (r && (w || f || dt)) rst_pins[d]++;
    if (l1 && done_cyc[d] == 0) done_cyc[d] = cyc[d];
    pw[d] = w; pf[d] = f; pd[d] = dt; pr[d] = r;
  endtask

  task automatic step();
    @(negedge clk);
    sample(0, outs_a);
    sample(1, outs_b);
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!(d == 0 ? l1_a : l1_b) && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", (d == 0 ? l1_a : l1_b), 1'b1);
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic verify_run(input int d, input logic [39:0] exp_word, input int div);
    logic [5:0] o;
    o = (d == 0) ? outs_a : outs_b;
    check("rst_pulses",    r_n[d], 1);
    check("rst_width",     r_len[d], RSTC);
    check("led2_with_rst", led2_rst[d], 1'b1);
    check("pins_in_rst",   rst_pins[d], 0);
    check("wclk_pulses",   w_n[d], 41);
    check("fqud_pulses",   f_n[d], 2);
    check("wclk_hi_min",   w_min[d], div);
    check("wclk_hi_max",   w_max[d], div);
    check("fqud_hi_min",   f_min[d], div);
    check("fqud_hi_max",   f_max[d], div);
    check("entry_order",   (w1_cyc[d] > rfall_cyc[d]) && (f1_cyc[d] > w1_cyc[d]) &&
                           (f1_cyc[d] < w2_cyc[d]), 1'b1);
    check("word",          cap[d][39:0], exp_word);
    check("latch_after",   f2_cyc[d] > wlast_cyc[d], 1'b1);
    check("overlap",       overlap[d], 0);
    check("data_glitch",   glitch[d], 0);
    check("led_both",      both[d], 0);
    check("duration",      (done_cyc[d] > 0) && (done_cyc[d] < 1000), 1'b1);
    check("final_pins",    o[5:2], 4'b0000);
    check("final_leds",    o[1:0], 2'b10);
  endtask

  task automatic abort_and_rerun(input int k, input int extra, input string tag);
    int n = 0;
    while (w_n[0] < k && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_reach"}, w_n[0] >= k, 1'b1);
    for (int i = 0; i < extra; i++) step();
    reset_a = 1'b1;
    #1;
    check({tag, "_outs"}, outs_a, 6'b0);
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
      step();
      check({tag, "_hold"}, outs_a, 6'b0);
    end
    clear_stats(0);
    reset_a = 1'b0;
    wait_done(0, 2000);
    verify_run(0, {CTRL_A, FTW_A}, DIV_A);
  endtask

  initial begin
    clear_stats(0);
    clear_stats(1);
    #1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_outs_a", outs_a, 6'b0);
      check("reset_outs_b", outs_b, 6'b0);
    end
    clear_stats(0);
    clear_stats(1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    wait_done(0, 2000);
    wait_done(1, 2000);
    verify_run(0, {CTRL_A, FTW_A}, DIV_A);
    verify_run(1, {CTRL_B, FTW_B}, DIV_B);
    check("sweep_ftw_ones", cap[1][31:0], 32'hFFFFFFFF);
    check("sweep_bit34",    cap[1][34], 1'b1);
    check("sweep_ctrl_rest", {cap[1][39:35], cap[1][33:32]}, 7'b0);

    clear_stats(1);
    // Abort during bit 20: 21 rises = entry pulse + bits 0..19.
    abort_and_rerun(21, 3, "abort20");
    for (int t = 0; t < 3; t++) begin
      abort_and_rerun(int'($urandom_range(1, 41)), int'($urandom_range(0, 4)), "abort_rnd");
    end

    check("b_terminal_wclk", w_n[1], 0);
    check("b_terminal_fqud", f_n[1], 0);
    check("b_terminal_outs", outs_b, 6'b000010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
